mm_job_regfile: RTL and testbench
=================================

// Module: mm_job_regfile
// PURPOSE
//  APB slave register file for the matrix multiplier, next generation of the single-job regfile.
//  Software stages A/B/C base addresses and M/N/P dimensions, then pushes them as a job into a
//  QUEUE_DEPTH-deep descriptor FIFO. The FIFO head goes to the engine over a valid/ready handshake.
//  Adds a busy/done status with W1C semantics, an interrupt, and APB pslverr reporting.
// PARAMETERS
//  ADDR_W       16  width of matrix base addresses
//  DIM_W        16  width of M/N/P dimensions
//  QUEUE_DEPTH  4   job FIFO depth, >=2, power of two
//  APB_AW       4   APB word-address width (paddr is a word index)
// PORTS
//  pclk         in   1             clock
//  preset       in   1             reset; one clock, asynchronous, active-high
//  psel,penable,pwrite in 1 each   APB control
//  paddr        in   APB_AW        register word index
//  pwdata       in   32            write data
//  prdata       out  32            read data, valid while pready=1
//  pready       out  1             always 1 in access phase (zero wait states)
//  pslverr      out  1             error, qualified by psel&penable
//  job_valid_o  out  1             FIFO not empty
//  job_ready_i  in   1             engine accepts head job
//  job_a_o,job_b_o,job_c_o out ADDR_W  head job base addresses
//  job_m_o,job_n_o,job_p_o out DIM_W   head job dimensions
//  done_i       in   1             1-cycle pulse: current job finished
//  irq_o        out  1             done & IRQ_EN, registered
// BEHAVIOUR
//  Map: 0 A, 1 B, 2 C, 3 M, 4 N, 5 P (staging, RW).
//   6 CTRL: b0 PUSH (WO, reads 0), b1 IRQ_EN (RW).
//   7 STATUS: b0 busy (RO), b1 done (W1C), b2 full, b3 empty, b[11:8] count (all RO).
//   8 ID = 32'h4D4D_0002 (RO).
//  Write commits on psel&penable&pwrite. Reads are combinational from the current state.
//  Staging fields: zero-extend on read, truncate on write.
//  pslverr=1 (no state change) for:
//   - paddr>8 (and >9 with PERF);
//   - writes to ID;
//   - PUSH while full;
//   - PUSH with any of M/N/P == 0.
//  Writes to STATUS bits other than b1 are ignored; this is not an error.
//  Queue:
//   - PUSH enqueues the staging set.
//   - Pop on job_valid_o&job_ready_i.
//   - Push and pop in the same cycle leave count unchanged.
//   - Pointers wrap modulo QUEUE_DEPTH.
//   - job_* outputs are stable while job_valid_o=1 && !job_ready_i.
//   - job_* outputs are 0 when empty.
//  Busy: set on pop; cleared on done_i. done_i with busy=0 is ignored.
//   Engine must not assert job_ready_i while busy. If pop and done_i coincide, busy stays 1.
//  Done: set on done_i (busy=1). Cleared by writing 1 to STATUS.b1. Set wins over clear.
//  irq_o <= done & IRQ_EN, one cycle after the done flag.
//  Reset (async, any time, including mid-job or mid-APB):
//   - All registers, FIFO pointers, busy, done and irq_o = 0; empty=1.
//   - prdata=0, pslverr=0, pready=1, job_valid_o=0.
//   - Queued jobs are discarded.
// CONFIGURATION
//  MM_JOB_REGFILE_PERF_EN defined:
//   - Adds reg 9 PERF: a 32-bit cycle counter, incremented every cycle busy=1 and saturating at FFFF_FFFF.
//   - Any write to reg 9 clears it; a concurrent increment is lost.
//  Not defined: reg 9 does not exist, and an access to it sets pslverr.
// TESTING
//  - Reset: pulse preset mid-APB write -> all reads 0, STATUS=0x0000_0008, job_valid_o=0.
//  - Job path: write A=0x100,B=0x200,C=0x300,M=2,N=3,P=4, PUSH -> job_valid_o=1, fields match.
//    Then job_ready_i 1 cycle -> busy=1, empty. Then done_i -> busy=0, done=1.
//  - Full queue: 4 PUSHes with job_ready_i=0 -> full=1, count=4.
//    5th PUSH -> pslverr=1, count stays 4. Pops return jobs in FIFO order.
//  - Simultaneous: PUSH with pop in the same cycle -> count unchanged.
//    W1C done with done_i in the same cycle -> done stays 1.
//  - IRQ and errors: IRQ_EN=1, done_i -> irq_o=1 next cycle. W1C -> irq_o=0.
//    PUSH with N=0 -> pslverr, no enqueue. Read paddr=15 -> pslverr.
//  - PERF_EN: busy for 10 cycles -> reg 9 reads 10. Write reg 9 -> reads 0.
//    Without the macro, access to reg 9 -> pslverr.

Source files
------------

// File: rtl/mm_job_regfile.sv
// mm_job_regfile: APB register file and job descriptor FIFO for the matrix multiplier.
// Software stages A/B/C base addresses and M/N/P dimensions, then pushes them as a job
// into a QUEUE_DEPTH-deep FIFO whose head is offered to the engine over valid/ready.
// Tracks busy/done status (done is write-1-to-clear), raises irq_o and reports pslverr.
// Optional feature: define MM_JOB_REGFILE_PERF_EN to add the busy-cycle counter at reg 9.
module mm_job_regfile #(
    parameter int ADDR_W      = 16,
    parameter int DIM_W       = 16,
    parameter int QUEUE_DEPTH = 4,
    parameter int APB_AW      = 4
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [APB_AW-1:0] paddr,
    input  logic [31:0]       pwdata,
    output logic [31:0]       prdata,
    output logic              pready,
    output logic              pslverr,
    output logic              job_valid_o,
    input  logic              job_ready_i,
    output logic [ADDR_W-1:0] job_a_o,
    output logic [ADDR_W-1:0] job_b_o,
    output logic [ADDR_W-1:0] job_c_o,
    output logic [DIM_W-1:0]  job_m_o,
    output logic [DIM_W-1:0]  job_n_o,
    output logic [DIM_W-1:0]  job_p_o,
    input  logic              done_i,
    output logic              irq_o
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [APB_AW-1:0] REG_A      = APB_AW'(0);
    localparam logic [APB_AW-1:0] REG_B      = APB_AW'(1);
    localparam logic [APB_AW-1:0] REG_C      = APB_AW'(2);
    localparam logic [APB_AW-1:0] REG_M      = APB_AW'(3);
    localparam logic [APB_AW-1:0] REG_N      = APB_AW'(4);
    localparam logic [APB_AW-1:0] REG_P      = APB_AW'(5);
    localparam logic [APB_AW-1:0] REG_CTRL   = APB_AW'(6);
    localparam logic [APB_AW-1:0] REG_STATUS = APB_AW'(7);
    localparam logic [APB_AW-1:0] REG_ID     = APB_AW'(8);
`ifdef MM_JOB_REGFILE_PERF_EN
    localparam logic [APB_AW-1:0] REG_PERF   = APB_AW'(9);
    localparam logic [APB_AW-1:0] LAST_REG   = REG_PERF;
`else
    localparam logic [APB_AW-1:0] LAST_REG   = REG_ID;
`endif
    localparam logic [31:0] ID_VALUE = 32'h4D4D_0002;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [ADDR_W-1:0] b;
        logic [ADDR_W-1:0] c;
        logic [DIM_W-1:0]  m;
        logic [DIM_W-1:0]  n;
        logic [DIM_W-1:0]  p;
    } job_t;

    logic [ADDR_W-1:0] stage_a, stage_b, stage_c;
    logic [DIM_W-1:0]  stage_m, stage_n, stage_p;
    logic              irq_en;
    logic              busy;
    logic              done;
    job_t              fifo_q [QUEUE_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              full, empty;
    logic              access, apb_wr, apb_rd, push_req, dims_zero, err;
    logic              wr_ok, push, pop, w1c;
    logic [31:0]       rd_data;
    logic [31:0]       status_word;
    job_t              head;
    logic              unused_bits;
`ifdef MM_JOB_REGFILE_PERF_EN
    logic [31:0]       perf_cnt;
`endif

    assign unused_bits = ^pwdata;

    assign full      = (count == CNT_W'(QUEUE_DEPTH));
    assign empty     = (count == '0);
    assign access    = psel & penable & ~preset;
    assign apb_wr    = access & pwrite;
    assign apb_rd    = access & ~pwrite;
    assign push_req  = pwrite & (paddr == REG_CTRL) & pwdata[0];
    assign dims_zero = (stage_m == '0) | (stage_n == '0) | (stage_p == '0);

    // Erroring accesses are rejected as a whole, so no register sees the write
    assign err     = (paddr > LAST_REG) | (pwrite & (paddr == REG_ID)) |
                     (push_req & (full | dims_zero));
    assign wr_ok   = apb_wr & ~err;
    assign push    = wr_ok & (paddr == REG_CTRL) & pwdata[0];
    assign w1c     = wr_ok & (paddr == REG_STATUS) & pwdata[1];
    assign pop     = job_valid_o & job_ready_i;
    assign pready  = 1'b1;
    assign pslverr = access & err;

    assign job_valid_o = ~empty;
    assign head        = empty ? '0 : fifo_q[rd_ptr];
    assign job_a_o     = head.a;
    assign job_b_o     = head.b;
    assign job_c_o     = head.c;
    assign job_m_o     = head.m;
    assign job_n_o     = head.n;
    assign job_p_o     = head.p;

    // Assemble the status word and select read data from the current register state
    always_comb begin
        status_word       = '0;
        status_word[0]    = busy;
        status_word[1]    = done;
        status_word[2]    = full;
        status_word[3]    = empty;
        status_word[11:8] = 4'(count);
        rd_data           = '0;
        case (paddr)
            REG_A:      rd_data = 32'(stage_a);
            REG_B:      rd_data = 32'(stage_b);
            REG_C:      rd_data = 32'(stage_c);
            REG_M:      rd_data = 32'(stage_m);
            REG_N:      rd_data = 32'(stage_n);
            REG_P:      rd_data = 32'(stage_p);
            REG_CTRL:   rd_data = {30'b0, irq_en, 1'b0};
            REG_STATUS: rd_data = status_word;
            REG_ID:     rd_data = ID_VALUE;
`ifdef MM_JOB_REGFILE_PERF_EN
            REG_PERF:   rd_data = perf_cnt;
`endif
            default:    rd_data = '0;
        endcase
        prdata = (apb_rd & ~err) ? rd_data : '0;
    end

    // Staging registers and the interrupt enable take accepted APB writes
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            stage_a <= '0;
            stage_b <= '0;
            stage_c <= '0;
            stage_m <= '0;
            stage_n <= '0;
            stage_p <= '0;
            irq_en  <= 1'b0;
        end else if (wr_ok) begin
            case (paddr)
                REG_A:    stage_a <= pwdata[ADDR_W-1:0];
                REG_B:    stage_b <= pwdata[ADDR_W-1:0];
                REG_C:    stage_c <= pwdata[ADDR_W-1:0];
                REG_M:    stage_m <= pwdata[DIM_W-1:0];
                REG_N:    stage_n <= pwdata[DIM_W-1:0];
                REG_P:    stage_p <= pwdata[DIM_W-1:0];
                REG_CTRL: irq_en  <= pwdata[1];
                default:  ;
            endcase
        end
    end

    // Descriptor FIFO: push copies the staging set, pop advances the head, pointers wrap
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) fifo_q[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr] <= '{a: stage_a, b: stage_b, c: stage_c,
                                    m: stage_m, n: stage_n, p: stage_p};
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Engine status: a pop starts a job, done_i ends it; done set beats software clear
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            busy  <= 1'b0;
            done  <= 1'b0;
            irq_o <= 1'b0;
        end else begin
            if (pop)         busy <= 1'b1;
            else if (done_i) busy <= 1'b0;
            if (done_i && busy) done <= 1'b1;
            else if (w1c)       done <= 1'b0;
            irq_o <= done & irq_en;
        end
    end

`ifdef MM_JOB_REGFILE_PERF_EN
    // Saturating count of busy cycles; a write to the register clears it and wins
    always_ff @(posedge pclk or posedge preset) begin
        if (preset)                                perf_cnt <= '0;
        else if (wr_ok && (paddr == REG_PERF))     perf_cnt <= '0;
        else if (busy && (perf_cnt != 32'hFFFF_FFFF)) perf_cnt <= perf_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_mm_job_regfile.sv
// tb_mm_job_regfile: scoreboard bench for mm_job_regfile. Stimulus drives one clock at a
// time and advances a behavioural model, pushing expected APB responses and expected job
// pops into queues; a monitor on the falling edge pops and compares what the DUT presents.
module tb_mm_job_regfile;

    logic        pclk = 1'b0;
    logic        preset, psel, penable, pwrite;
    logic [3:0]  paddr;
    logic [31:0] pwdata, prdata;
    logic        pready, pslverr, job_valid_o, job_ready_i, done_i, irq_o;
    logic [15:0] job_a_o, job_b_o, job_c_o, job_m_o, job_n_o, job_p_o;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic [31:0] data;
        bit          err;
        bit          is_read;
        string       name;
    } apb_exp_t;

    typedef struct {
        logic [15:0] a, b, c, m, n, p;
    } job_t;

    apb_exp_t    exp_apb[$];
    job_t        exp_job[$];
    job_t        mq[$];
    logic [31:0] m_stage[6];
    bit          m_irq_en, m_busy, m_done, m_irq;
    logic [31:0] m_perf;
    logic [31:0] last_rdata;
    bit          last_err;
    apb_exp_t    mon_e;
    job_t        mon_j;

`ifdef MM_JOB_REGFILE_PERF_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif

    mm_job_regfile dut (
        .pclk(pclk), .preset(preset), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .job_valid_o(job_valid_o), .job_ready_i(job_ready_i),
        .job_a_o(job_a_o), .job_b_o(job_b_o), .job_c_o(job_c_o),
        .job_m_o(job_m_o), .job_n_o(job_n_o), .job_p_o(job_p_o),
        .done_i(done_i), .irq_o(irq_o)
    );

    always #5 pclk = ~pclk;

    // Monitor: compare each APB access phase and each job handshake against the scoreboard
    always @(negedge pclk) begin
        if (!preset && psel && penable) begin
            tests_run++;
            if (exp_apb.size() == 0) begin
                tests_failed++;
                $display("[TB] FAIL apb_unexpected: access at paddr=%0d with no expectation", paddr);
            end else begin
                mon_e = exp_apb.pop_front();
                if (pslverr !== mon_e.err || pready !== 1'b1 ||
                    (mon_e.is_read && prdata !== mon_e.data)) begin
                    tests_failed++;
                    $display("[TB] FAIL %s: got prdata=%h pslverr=%b pready=%b, want prdata=%h pslverr=%b",
                             mon_e.name, prdata, pslverr, pready, mon_e.data, mon_e.err);
                end
                last_rdata = prdata;
                last_err   = pslverr;
            end
        end
        if (!preset && job_valid_o && job_ready_i) begin
            tests_run++;
            if (exp_job.size() == 0) begin
                tests_failed++;
                $display("[TB] FAIL job_unexpected: DUT popped a=%h with no job expected", job_a_o);
            end else begin
                mon_j = exp_job.pop_front();
                if ({job_a_o, job_b_o, job_c_o, job_m_o, job_n_o, job_p_o} !==
                    {mon_j.a, mon_j.b, mon_j.c, mon_j.m, mon_j.n, mon_j.p}) begin
                    tests_failed++;
                    $display("[TB] FAIL job_pop: got %h/%h/%h %0d/%0d/%0d, want %h/%h/%h %0d/%0d/%0d",
                             job_a_o, job_b_o, job_c_o, job_m_o, job_n_o, job_p_o,
                             mon_j.a, mon_j.b, mon_j.c, mon_j.m, mon_j.n, mon_j.p);
                end
            end
        end
    end

    function automatic logic [31:0] modelStatus();
        return {20'b0, 4'(mq.size()), 4'b0, mq.size() == 0, mq.size() == 4, m_done, m_busy};
    endfunction

    task automatic resetModel();
        for (int i = 0; i < 6; i++) m_stage[i] = '0;
        m_irq_en = 0; m_busy = 0; m_done = 0; m_irq = 0; m_perf = '0;
        mq.delete();
        exp_job.delete();
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
        end
    endtask

    // One clock: drive inputs, record expectations from the model, advance the model
    task automatic applyStimulus(input bit sel, input bit en, input bit wr, input logic [3:0] addr,
                                 input logic [31:0] wd, input bit rdy, input bit dn, input string name);
        bit          acc, err, full, dz, pop, acc_wr, new_busy, new_done;
        logic [31:0] rd;
        job_t        j;
        psel = sel; penable = en; pwrite = wr; paddr = addr; pwdata = wd;
        job_ready_i = rdy; done_i = dn;
        acc  = sel && en;
        full = (mq.size() == 4);
        dz   = (m_stage[3] == 0) || (m_stage[4] == 0) || (m_stage[5] == 0);
        err  = acc && ((addr > (PERF_EN ? 9 : 8)) || (wr && addr == 8) ||
                       (wr && addr == 6 && wd[0] && (full || dz)));
        rd   = '0;
        if (acc && !wr && !err) begin
            if (addr < 6)       rd = m_stage[addr];
            else if (addr == 6) rd = {30'b0, m_irq_en, 1'b0};
            else if (addr == 7) rd = modelStatus();
            else if (addr == 8) rd = 32'h4D4D_0002;
            else                rd = m_perf;
        end
        if (acc) exp_apb.push_back('{rd, err, !wr, name});
        acc_wr   = acc && wr && !err;
        pop      = rdy && (mq.size() > 0);
        new_busy = pop ? 1'b1 : (dn ? 1'b0 : m_busy);
        new_done = (dn && m_busy) ? 1'b1 : ((acc_wr && addr == 7 && wd[1]) ? 1'b0 : m_done);
        m_irq    = m_done && m_irq_en;
        if (PERF_EN) begin
            if (acc_wr && addr == 9)                m_perf = '0;
            else if (m_busy && m_perf != '1)        m_perf = m_perf + 1;
        end
        if (pop) begin
            j = mq.pop_front();
            exp_job.push_back(j);
        end
        if (acc_wr) begin
            if (addr < 6) m_stage[addr] = wd & 32'h0000_FFFF;
            else if (addr == 6) begin
                m_irq_en = wd[1];
                if (wd[0]) mq.push_back('{m_stage[0][15:0], m_stage[1][15:0], m_stage[2][15:0],
                                           m_stage[3][15:0], m_stage[4][15:0], m_stage[5][15:0]});
            end
        end
        m_busy = new_busy;
        m_done = new_done;
        @(posedge pclk);
        #1;
    endtask

    task automatic apbWrite(input logic [3:0] addr, input logic [31:0] wd, input bit rdy, input bit dn,
                            input string name);
        applyStimulus(1, 0, 1, addr, wd, 0, 0, name);
        applyStimulus(1, 1, 1, addr, wd, rdy, dn, name);
        applyStimulus(0, 0, 0, 4'd0, 32'd0, 0, 0, "idle");
    endtask

    task automatic apbRead(input logic [3:0] addr, input string name);
        applyStimulus(1, 0, 0, addr, 32'd0, 0, 0, name);
        applyStimulus(1, 1, 0, addr, 32'd0, 0, 0, name);
        applyStimulus(0, 0, 0, 4'd0, 32'd0, 0, 0, "idle");
    endtask

    task automatic idle(input bit rdy, input bit dn);
        applyStimulus(0, 0, 0, 4'd0, 32'd0, rdy, dn, "idle");
    endtask

    task automatic stageJob(input logic [31:0] a, input logic [31:0] m, input logic [31:0] n,
                            input logic [31:0] p);
        apbWrite(4'd0, a, 0, 0, "wr_a");
        apbWrite(4'd1, a + 32'h100, 0, 0, "wr_b");
        apbWrite(4'd2, a + 32'h200, 0, 0, "wr_c");
        apbWrite(4'd3, m, 0, 0, "wr_m");
        apbWrite(4'd4, n, 0, 0, "wr_n");
        apbWrite(4'd5, p, 0, 0, "wr_p");
    endtask

    initial begin
        preset = 1; psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0;
        job_ready_i = 0; done_i = 0;
        resetModel();
        repeat (2) @(posedge pclk);
        #1 preset = 0;

        // Build some state, then reset in the middle of an APB write
        stageJob(32'h55, 1, 1, 1);
        apbWrite(4'd6, 32'h3, 0, 0, "push_pre_reset");
        idle(1, 0);
        applyStimulus(1, 0, 1, 4'd1, 32'hDEAD, 0, 0, "wr_mid_reset");
        penable = 1;
        #2 preset = 1;
        #1;
        checkOutput("rst_job_valid", {31'b0, job_valid_o}, 32'd0);
        checkOutput("rst_pslverr", {31'b0, pslverr}, 32'd0);
        checkOutput("rst_prdata", prdata, 32'd0);
        checkOutput("rst_pready", {31'b0, pready}, 32'd1);
        checkOutput("rst_irq", {31'b0, irq_o}, 32'd0);
        @(posedge pclk);
        #1;
        psel = 0; penable = 0; preset = 0;
        resetModel();
        apbRead(4'd0, "rd_a_after_rst");
        checkOutput("rst_a", last_rdata, 32'd0);
        apbRead(4'd7, "rd_status_after_rst");
        checkOutput("rst_status", last_rdata, 32'h0000_0008);
        apbRead(4'd8, "rd_id");
        checkOutput("id", last_rdata, 32'h4D4D_0002);

        // Job path: stage, push, pop, done
        apbWrite(4'd0, 32'h100, 0, 0, "wr_a");
        apbWrite(4'd1, 32'h200, 0, 0, "wr_b");
        apbWrite(4'd2, 32'h300, 0, 0, "wr_c");
        apbWrite(4'd3, 32'd2, 0, 0, "wr_m");
        apbWrite(4'd4, 32'd3, 0, 0, "wr_n");
        apbWrite(4'd5, 32'h0001_0004, 0, 0, "wr_p_trunc");
        apbRead(4'd5, "rd_p_trunc");
        checkOutput("trunc_p", last_rdata, 32'd4);
        apbWrite(4'd6, 32'h1, 0, 0, "push_job");
        checkOutput("job_valid", {31'b0, job_valid_o}, 32'd1);
        checkOutput("job_fields", {job_a_o, job_p_o}, {16'h100, 16'd4});
        idle(1, 0);
        apbRead(4'd7, "rd_status_busy");
        checkOutput("status_busy", last_rdata, 32'h0000_0009);
        idle(0, 1);
        apbRead(4'd7, "rd_status_done");
        checkOutput("status_done", last_rdata, 32'h0000_000A);

        // Full queue, overflow push, FIFO-order pops
        apbWrite(4'd7, 32'h2, 0, 0, "w1c_done");
        for (int i = 1; i <= 4; i++) begin
            apbWrite(4'd0, 32'(i * 16), 0, 0, "wr_a_fill");
            apbWrite(4'd6, 32'h1, 0, 0, "push_fill");
        end
        apbRead(4'd7, "rd_status_full");
        checkOutput("status_full", last_rdata, 32'h0000_0404);
        apbWrite(4'd6, 32'h1, 0, 0, "push_overflow");
        checkOutput("overflow_err", {31'b0, last_err}, 32'd1);
        apbRead(4'd7, "rd_status_still_full");
        checkOutput("count_still4", last_rdata, 32'h0000_0404);
        for (int i = 1; i <= 4; i++) begin
            checkOutput("fifo_order", {16'b0, job_a_o}, 32'(i * 16));
            idle(1, 0);
            idle(0, 1);
        end

        // Push and pop in the same cycle; done_i racing a W1C
        apbWrite(4'd6, 32'h1, 0, 0, "push_s1");
        apbWrite(4'd6, 32'h1, 0, 0, "push_s2");
        apbWrite(4'd6, 32'h1, 1, 0, "push_with_pop");
        apbRead(4'd7, "rd_status_simul");
        checkOutput("simul_count", last_rdata, 32'h0000_0203);
        apbWrite(4'd7, 32'h2, 0, 1, "w1c_with_done");
        apbRead(4'd7, "rd_status_w1c_race");
        checkOutput("done_wins", last_rdata, 32'h0000_0202);

        // Interrupt timing and clearing
        apbWrite(4'd7, 32'h2, 0, 0, "w1c_clear");
        apbWrite(4'd6, 32'h2, 0, 0, "irq_en");
        idle(1, 0);
        idle(0, 1);
        checkOutput("irq_not_yet", {31'b0, irq_o}, 32'd0);
        idle(0, 0);
        checkOutput("irq_set", {31'b0, irq_o}, 32'd1);
        apbWrite(4'd7, 32'h2, 0, 0, "w1c_irq");
        idle(0, 0);
        checkOutput("irq_cleared", {31'b0, irq_o}, 32'd0);

        // Error responses
        apbWrite(4'd4, 32'd0, 0, 0, "wr_n_zero");
        apbWrite(4'd6, 32'h3, 0, 0, "push_dim_zero");
        checkOutput("dim_zero_err", {31'b0, last_err}, 32'd1);
        apbRead(4'd7, "rd_status_no_enq");
        checkOutput("no_enqueue", last_rdata, 32'h0000_0100);
        apbRead(4'd15, "rd_addr15");
        checkOutput("addr15_err", {31'b0, last_err}, 32'd1);
        apbWrite(4'd8, 32'h1234, 0, 0, "wr_id");
        checkOutput("wr_id_err", {31'b0, last_err}, 32'd1);
        apbRead(4'd9, "rd_reg9");
        checkOutput("reg9_err", {31'b0, last_err}, PERF_EN ? 32'd0 : 32'd1);
        apbWrite(4'd4, 32'd5, 0, 0, "wr_n_restore");

`ifdef MM_JOB_REGFILE_PERF_EN
        // Busy-cycle counter: ten busy cycles, then cleared by a write
        apbWrite(4'd9, 32'd0, 0, 0, "perf_clear");
        idle(1, 0);
        repeat (9) idle(0, 0);
        idle(0, 1);
        apbRead(4'd9, "rd_perf10");
        checkOutput("perf_ten", last_rdata, 32'd10);
        apbWrite(4'd9, 32'hFFFF, 0, 0, "perf_clear2");
        apbRead(4'd9, "rd_perf0");
        checkOutput("perf_zero", last_rdata, 32'd0);
`endif

        // Randomised traffic checked entirely through the scoreboard
        for (int k = 0; k < 400; k++) begin
            logic [3:0]  addr;
            logic [31:0] wd;
            bit          wr, rdy, dn;
            addr = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
            wr   = $urandom_range(0, 1) == 1;
            wd   = $urandom();
            if (addr >= 3 && addr <= 5) wd = 32'($urandom_range(0, 3));
            if (addr == 6 || addr == 7) wd = 32'($urandom_range(0, 3));
            rdy = !m_busy && ($urandom_range(0, 3) == 0);
            dn  = $urandom_range(0, 4) == 0;
            applyStimulus(1, 0, wr, addr, wd, 0, 0, "rand");
            applyStimulus(1, 1, wr, addr, wd, rdy, dn, "rand");
            rdy = !m_busy && ($urandom_range(0, 2) == 0);
            idle(rdy, $urandom_range(0, 3) == 0);
        end

        idle(0, 0);
        checkOutput("apb_drained", 32'(exp_apb.size()), 32'd0);
        checkOutput("jobs_drained", 32'(exp_job.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
